// File: rtl/master_seq_core.sv
// master_seq_core: command-table driven bus master sequencer.
// Runs WRITE/READ/IDLE/END commands from a writable table and drives the
// master-interface address/data handshakes with a per-wait response timeout.
module master_seq_core #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 3,
  parameter int LEN_W      = 8,
  parameter int TIMEOUT    = 255,
  parameter int CMD_W      = 2 + 2 + ADDR_W + LEN_W + 2 * DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_wr_en,
  input  logic [DEPTH_LOG2-1:0] cmd_wr_addr,
  input  logic [CMD_W-1:0]      cmd_wr_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  rd_valid,
  output logic [DATA_W-1:0]     rd_data,
  output logic [ADDR_W-1:0]     rd_addr,
  output logic [ADDR_W+3:0]     addr_to_mi,
  output logic                  write_addr_req_to_mi,
  output logic [DATA_W-1:0]     write_data_to_mi,
  output logic                  write_data_req_to_mi,
  output logic                  read_data_req_to_mi,
  output logic                  force_req_to_mi,
  input  logic                  ok_response_from_mi,
  input  logic [DATA_W-1:0]     read_data_from_mi,
  input  logic                  req_done_from_mi
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [1:0] OP_IDLE  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE, FETCH, GAP, SETUP, ADDR_RQ, ADDR_WAIT,
    WD_SETUP, WD_RQ, RD_RQ, DATA_WAIT, NEXT, FINISH
  } state_t;

  state_t state, state_nxt;

  logic [CMD_W-1:0]      cmd_table [DEPTH];
  logic [DEPTH_LOG2-1:0] pc, pc_nxt;
  logic [LEN_W-1:0]      cnt, cnt_nxt;
  logic [TMO_W-1:0]      tmo, tmo_nxt, tmo_inc;
  logic                  tmo_hit;

  // working copy of the command being executed
  logic [1:0]        cur_op, cur_op_nxt;
  logic [1:0]        cur_slave, cur_slave_nxt;
  logic [ADDR_W-1:0] cur_addr, cur_addr_nxt;
  logic [DATA_W-1:0] cur_data, cur_data_nxt;
  logic [DATA_W-1:0] cur_incr, cur_incr_nxt;

  logic                busy_nxt, done_nxt, error_nxt, rd_valid_nxt;
  logic [DATA_W-1:0]   rd_data_nxt, wdata_nxt;
  logic [ADDR_W-1:0]   rd_addr_nxt;
  logic [ADDR_W+3:0]   addr_mi_nxt;
  logic                areq_nxt, wreq_nxt, rreq_nxt, force_nxt;

  // decoded fields of the entry addressed by pc
  logic [CMD_W-1:0]  cmd_word;
  logic [1:0]        f_op, f_slave;
  logic [ADDR_W-1:0] f_addr;
  logic [LEN_W-1:0]  f_len;
  logic [DATA_W-1:0] f_seed, f_incr;

  assign cmd_word = cmd_table[pc];
  assign f_op     = cmd_word[CMD_W-1 -: 2];
  assign f_slave  = cmd_word[CMD_W-3 -: 2];
  assign f_addr   = cmd_word[2*DATA_W+LEN_W +: ADDR_W];
  assign f_len    = cmd_word[2*DATA_W +: LEN_W];
  assign f_seed   = cmd_word[DATA_W +: DATA_W];
  assign f_incr   = cmd_word[0 +: DATA_W];

  assign tmo_inc = tmo + 1'b1;
  assign tmo_hit = (TIMEOUT != 0) && (tmo_inc == TMO_W'(TIMEOUT));

  // command table: host writes land only while the sequencer is idle
  always_ff @(posedge clk) begin
    if (cmd_wr_en && !busy) cmd_table[cmd_wr_addr] <= cmd_wr_data;
  end

  // state register plus control and interface outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                <= S_IDLE;
      pc                   <= '0;
      cnt                  <= '0;
      tmo                  <= '0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      error                <= 1'b0;
      rd_valid             <= 1'b0;
      rd_data              <= '0;
      rd_addr              <= '0;
      addr_to_mi           <= '0;
      write_addr_req_to_mi <= 1'b0;
      write_data_to_mi     <= '0;
      write_data_req_to_mi <= 1'b0;
      read_data_req_to_mi  <= 1'b0;
      force_req_to_mi      <= 1'b0;
    end else begin
      state                <= state_nxt;
      pc                   <= pc_nxt;
      cnt                  <= cnt_nxt;
      tmo                  <= tmo_nxt;
      busy                 <= busy_nxt;
      done                 <= done_nxt;
      error                <= error_nxt;
      rd_valid             <= rd_valid_nxt;
      rd_data              <= rd_data_nxt;
      rd_addr              <= rd_addr_nxt;
      addr_to_mi           <= addr_mi_nxt;
      write_addr_req_to_mi <= areq_nxt;
      write_data_to_mi     <= wdata_nxt;
      write_data_req_to_mi <= wreq_nxt;
      read_data_req_to_mi  <= rreq_nxt;
      force_req_to_mi      <= force_nxt;
    end
  end

  // working registers are only meaningful after FETCH, so they carry no reset
  always_ff @(posedge clk) begin
    cur_op    <= cur_op_nxt;
    cur_slave <= cur_slave_nxt;
    cur_addr  <= cur_addr_nxt;
    cur_data  <= cur_data_nxt;
    cur_incr  <= cur_incr_nxt;
  end

  // next-state and next-output decode for the sequencer
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    cnt_nxt       = cnt;
    tmo_nxt       = tmo;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    error_nxt     = error;
    rd_valid_nxt  = 1'b0;
    rd_data_nxt   = rd_data;
    rd_addr_nxt   = rd_addr;
    addr_mi_nxt   = addr_to_mi;
    areq_nxt      = write_addr_req_to_mi;
    wdata_nxt     = write_data_to_mi;
    wreq_nxt      = write_data_req_to_mi;
    rreq_nxt      = read_data_req_to_mi;
    force_nxt     = force_req_to_mi;
    cur_op_nxt    = cur_op;
    cur_slave_nxt = cur_slave;
    cur_addr_nxt  = cur_addr;
    cur_data_nxt  = cur_data;
    cur_incr_nxt  = cur_incr;
    case (state)
      S_IDLE: begin
        if (start) begin
          busy_nxt  = 1'b1;
          pc_nxt    = '0;
          error_nxt = 1'b0;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        cur_op_nxt    = f_op;
        cur_slave_nxt = f_slave;
        cur_addr_nxt  = f_addr;
        cur_data_nxt  = f_seed;
        cur_incr_nxt  = f_incr;
        cnt_nxt       = f_len;
        if (f_op == OP_WRITE || f_op == OP_READ)
          state_nxt = (f_len != '0) ? SETUP : NEXT;
        else if (f_op == OP_IDLE)
          state_nxt = (f_len != '0) ? GAP : NEXT;
        else
          state_nxt = FINISH;
      end
      GAP: begin
        // entered only with a nonzero count, so exactly len cycles are spent here
        cnt_nxt = cnt - 1'b1;
        if (cnt == LEN_W'(1)) state_nxt = NEXT;
      end
      SETUP: begin
        addr_mi_nxt = {1'b1, cur_slave, (cur_op == OP_WRITE), cur_addr};
        force_nxt   = 1'b0;
        cnt_nxt     = cnt - 1'b1;
        state_nxt   = ADDR_RQ;
      end
      ADDR_RQ: begin
        areq_nxt  = 1'b1;
        tmo_nxt   = '0;
        state_nxt = ADDR_WAIT;
      end
      ADDR_WAIT: begin
        // a response arriving on the expiry cycle still wins
        if (ok_response_from_mi) begin
          areq_nxt  = 1'b0;
          state_nxt = (cur_op == OP_WRITE) ? WD_SETUP : RD_RQ;
        end else if (tmo_hit) begin
          areq_nxt  = 1'b0;
          force_nxt = 1'b0;
          error_nxt = 1'b1;
          state_nxt = FINISH;
        end else begin
          tmo_nxt = tmo_inc;
        end
      end
      WD_SETUP: begin
        wdata_nxt    = cur_data;
        cur_data_nxt = cur_data + cur_incr;
        state_nxt    = WD_RQ;
      end
      WD_RQ: begin
        wreq_nxt  = 1'b1;
        tmo_nxt   = '0;
        state_nxt = DATA_WAIT;
      end
      RD_RQ: begin
        rreq_nxt  = 1'b1;
        tmo_nxt   = '0;
        state_nxt = DATA_WAIT;
      end
      DATA_WAIT: begin
        if (req_done_from_mi) begin
          wreq_nxt = 1'b0;
          rreq_nxt = 1'b0;
          if (cur_op == OP_READ) begin
            rd_data_nxt  = read_data_from_mi;
            rd_addr_nxt  = cur_addr;
            rd_valid_nxt = 1'b1;
          end
          cur_addr_nxt = cur_addr + 1'b1;
          if (cnt != '0) begin
            force_nxt = 1'b1;
            state_nxt = SETUP;
          end else begin
            state_nxt = NEXT;
          end
        end else if (tmo_hit) begin
          wreq_nxt  = 1'b0;
          rreq_nxt  = 1'b0;
          force_nxt = 1'b0;
          error_nxt = 1'b1;
          state_nxt = FINISH;
        end else begin
          tmo_nxt = tmo_inc;
        end
      end
      NEXT: begin
        if (&pc) begin
          state_nxt = FINISH;
        end else begin
          pc_nxt    = pc + 1'b1;
          state_nxt = FETCH;
        end
      end
      FINISH: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        areq_nxt  = 1'b0;
        wreq_nxt  = 1'b0;
        rreq_nxt  = 1'b0;
        force_nxt = 1'b0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_master_seq_core.sv
// Scoreboard bench for master_seq_core: a program-level reference model fills
// expectation queues, a slave responder answers the handshakes with random
// delays, and a monitor pops and compares every observed beat.
module tb_master_seq_core;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int DL = 3;
  localparam int LW = 8;
  localparam int TO = 20;
  localparam int CW = 2 + 2 + AW + LW + 2 * DW;

  localparam logic [1:0] OPI = 2'b00, OPW = 2'b01, OPR = 2'b10, OPE = 2'b11;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_wr_en = 1'b0;
  logic [DL-1:0] cmd_wr_addr = '0;
  logic [CW-1:0] cmd_wr_data = '0;
  logic          start = 1'b0;
  logic          busy, done, error, rd_valid;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] rd_addr;
  logic [AW+3:0] addr_to_mi;
  logic          write_addr_req_to_mi, write_data_req_to_mi, read_data_req_to_mi;
  logic [DW-1:0] write_data_to_mi;
  logic          force_req_to_mi;
  logic          ok_response_from_mi = 1'b0;
  logic [DW-1:0] read_data_from_mi = '0;
  logic          req_done_from_mi = 1'b0;

  master_seq_core #(.ADDR_W(AW), .DATA_W(DW), .DEPTH_LOG2(DL), .LEN_W(LW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_wr_en(cmd_wr_en), .cmd_wr_addr(cmd_wr_addr), .cmd_wr_data(cmd_wr_data),
    .start(start), .busy(busy), .done(done), .error(error),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_addr(rd_addr),
    .addr_to_mi(addr_to_mi), .write_addr_req_to_mi(write_addr_req_to_mi),
    .write_data_to_mi(write_data_to_mi), .write_data_req_to_mi(write_data_req_to_mi),
    .read_data_req_to_mi(read_data_req_to_mi), .force_req_to_mi(force_req_to_mi),
    .ok_response_from_mi(ok_response_from_mi), .read_data_from_mi(read_data_from_mi),
    .req_done_from_mi(req_done_from_mi)
  );

  always #5 clk = ~clk;

  logic [51:0] all_outs;
  assign all_outs = {busy, done, error, rd_valid, rd_data, rd_addr, addr_to_mi,
                     write_addr_req_to_mi, write_data_to_mi, write_data_req_to_mi,
                     read_data_req_to_mi, force_req_to_mi};

  typedef struct {
    logic [1:0] op; logic [1:0] slave; logic [AW-1:0] addr;
    logic [LW-1:0] len; logic [DW-1:0] seed; logic [DW-1:0] incr;
  } cmd_t;
  typedef struct { bit is_wr; logic [AW+3:0] aw; logic [DW-1:0] wd; } bus_t;
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } rd_t;

  cmd_t          shadow [8];
  bus_t          bus_q [$];
  rd_t           rd_q [$];
  logic [DW-1:0] bfm_rd_q [$];
  logic [DW-1:0] rd_pre [$];

  int n_vec = 0, n_err = 0;
  int force_cnt = 0, done_cnt = 0, areq_cnt = 0;
  bit bfm_mute = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: event with no matching expectation", nm);
  endtask

  function automatic logic [CW-1:0] pack(input cmd_t c);
    return {c.op, c.slave, c.addr, c.len, c.seed, c.incr};
  endfunction

  function automatic cmd_t mk(input logic [1:0] op, input logic [1:0] sl, input int a,
                              input int len, input int seed, input int incr);
    cmd_t c;
    c.op = op; c.slave = sl; c.addr = AW'(a); c.len = LW'(len);
    c.seed = DW'(seed); c.incr = DW'(incr);
    return c;
  endfunction

  task automatic write_cmd(input int idx, input cmd_t c);
    @(negedge clk);
    cmd_wr_en = 1'b1; cmd_wr_addr = DL'(idx); cmd_wr_data = pack(c);
    @(negedge clk);
    cmd_wr_en = 1'b0;
    shadow[idx] = c;
  endtask

  // Program-level model: walk the table, expand each command into its beats,
  // and count the cycles the sequencer spends before the first address update.
  task automatic build_expect(output int exp_force, output int exp_lat, output logic [AW+3:0] first_aw);
    int acc;
    logic [AW-1:0] a;
    logic [DW-1:0] d, v;
    bus_t b;
    rd_t r;
    exp_force = 0; exp_lat = -1; first_aw = '0; acc = 0;
    for (int pc = 0; pc < 8; pc++) begin
      cmd_t c = shadow[pc];
      if (c.op == OPE) break;
      if (c.op == OPI || c.len == 0) begin
        acc += 2 + ((c.op == OPI) ? int'(c.len) : 0);
        continue;
      end
      if (exp_lat < 0) begin
        exp_lat = acc + 2;
        first_aw = {1'b1, c.slave, c.op == OPW, c.addr};
      end
      exp_force += int'(c.len) - 1;
      a = c.addr; d = c.seed;
      for (int k = 0; k < int'(c.len); k++) begin
        b.is_wr = (c.op == OPW); b.aw = {1'b1, c.slave, c.op == OPW, a}; b.wd = d;
        bus_q.push_back(b);
        if (c.op == OPR) begin
          v = (rd_pre.size() > 0) ? rd_pre.pop_front() : DW'($urandom);
          bfm_rd_q.push_back(v);
          r.a = a; r.d = v;
          rd_q.push_back(r);
        end
        a = a + 1'b1;
        d = d + c.incr;
      end
    end
  endtask

  task automatic flush();
    bus_q.delete(); rd_q.delete(); bfm_rd_q.delete();
    force_cnt = 0; done_cnt = 0; areq_cnt = 0;
  endtask

  task automatic run_prog(input bit to_exp, output int lat);
    int ef, el, n, alat;
    logic [AW+3:0] fa, prev_aw;
    flush();
    build_expect(ef, el, fa);
    if (to_exp) begin
      bus_q.delete(); rd_q.delete(); bfm_rd_q.delete(); ef = 0;
    end
    prev_aw = addr_to_mi;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("error_cleared_on_start", error, 0);
    n = 0; lat = -1; alat = -1;
    while (busy && n < 5000) begin
      @(posedge clk); #1;
      n++;
      if (lat < 0 && addr_to_mi != prev_aw) lat = n;
      if (alat < 0 && write_addr_req_to_mi) alat = n;
    end
    if (n >= 5000) chk("prog_terminates", n, 0);
    repeat (2) @(negedge clk);
    chk("done_pulses", done_cnt, 1);
    chk("busy_fell", busy, 0);
    chk("error_flag", error, to_exp);
    chk("force_cycles", force_cnt, ef);
    chk("beats_left", bus_q.size(), 0);
    chk("reads_left", rd_q.size(), 0);
    chk("reqs_idle", {write_addr_req_to_mi, write_data_req_to_mi, read_data_req_to_mi, force_req_to_mi}, 0);
    if (el >= 0 && fa != prev_aw) begin
      chk("addr_latency", lat, el);
      chk("addr_req_latency", alat, el + 1);
    end
  endtask

  // slave responder: one-cycle ok / done pulses after a random delay
  initial begin
    int adly = 0, ddly = 0;
    forever begin
      @(posedge clk); #1;
      ok_response_from_mi = 1'b0;
      req_done_from_mi = 1'b0;
      if (!bfm_mute && reset) begin
        if (write_addr_req_to_mi) begin
          if (adly == 0) begin ok_response_from_mi = 1'b1; adly = $urandom_range(0, 3); end
          else adly--;
        end
        if (write_data_req_to_mi || read_data_req_to_mi) begin
          if (ddly == 0) begin
            req_done_from_mi = 1'b1;
            if (read_data_req_to_mi)
              read_data_from_mi = (bfm_rd_q.size() > 0) ? bfm_rd_q.pop_front() : 8'hEE;
            ddly = $urandom_range(0, 3);
          end else ddly--;
        end
      end
    end
  end

  // monitor: pop the scoreboard whenever the DUT completes a beat
  initial begin
    bus_t b;
    rd_t r;
    forever begin
      @(negedge clk);
      if (force_req_to_mi) force_cnt++;
      if (done) done_cnt++;
      if (write_addr_req_to_mi) areq_cnt++;
      if (req_done_from_mi && (write_data_req_to_mi || read_data_req_to_mi)) begin
        if (bus_q.size() == 0) fail_now("bus_beat");
        else begin
          b = bus_q.pop_front();
          chk("beat_is_write", write_data_req_to_mi, b.is_wr);
          chk("beat_addr_to_mi", addr_to_mi, b.aw);
          if (b.is_wr) chk("beat_write_data", write_data_to_mi, b.wd);
        end
      end
      if (rd_valid) begin
        if (rd_q.size() == 0) fail_now("rd_valid");
        else begin
          r = rd_q.pop_front();
          chk("rd_addr", rd_addr, r.a);
          chk("rd_data", rd_data, r.d);
        end
      end
    end
  end

  initial begin
    int lat, lat110, lat0, n;
    cmd_t c;
    repeat (3) @(negedge clk);
    chk("outputs_in_reset", all_outs, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("outputs_after_reset", all_outs, 0);
    for (int i = 0; i < 8; i++) write_cmd(i, mk(OPE, 0, 0, 0, 0, 0));

    // two-beat write
    write_cmd(0, mk(OPW, 1, 400, 2, 170, 15));
    run_prog(1'b0, lat);
    // two-beat read with fixed slave data
    rd_pre.push_back(8'h5A); rd_pre.push_back(8'hA5);
    write_cmd(0, mk(OPR, 1, 400, 2, 0, 0));
    run_prog(1'b0, lat);
    // address and data wrap
    write_cmd(0, mk(OPW, 0, 4095, 3, 250, 5));
    run_prog(1'b0, lat);
    // IDLE gap of 110 cycles, then of 0 cycles
    write_cmd(0, mk(OPI, 0, 0, 110, 0, 0));
    write_cmd(1, mk(OPW, 2, 7, 1, 33, 0));
    run_prog(1'b0, lat110);
    write_cmd(0, mk(OPI, 0, 0, 0, 0, 0));
    write_cmd(1, mk(OPW, 2, 8, 1, 34, 0));
    run_prog(1'b0, lat0);
    chk("gap_cycles", lat110 - lat0, 110);

    // timeout with no ok response, then a clean rerun clears error
    write_cmd(0, mk(OPW, 1, 'h300, 2, 9, 1));
    write_cmd(1, mk(OPE, 0, 0, 0, 0, 0));
    bfm_mute = 1'b1;
    run_prog(1'b1, lat);
    chk("timeout_req_cycles", areq_cnt, TO);
    bfm_mute = 1'b0;
    run_prog(1'b0, lat);

    // reset mid-beat
    write_cmd(0, mk(OPW, 3, 'h20, 4, 1, 1));
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!write_data_req_to_mi && n < 200) begin @(posedge clk); #1; n++; end
    chk("reached_data_phase", write_data_req_to_mi, 1);
    #2 reset = 1'b0;
    #1 chk("outputs_async_reset", all_outs, 0);
    @(negedge clk);
    chk("outputs_held_in_reset", all_outs, 0);
    flush();
    @(negedge clk);
    reset = 1'b1;

    // table retained across reset; writes and start while busy are ignored
    fork
      run_prog(1'b0, lat);
      begin
        repeat (8) @(negedge clk);
        cmd_wr_en = 1'b1; cmd_wr_addr = '0; cmd_wr_data = pack(mk(OPE, 0, 0, 0, 0, 0));
        start = 1'b1;
        @(negedge clk);
        cmd_wr_en = 1'b0; start = 1'b0;
      end
    join
    run_prog(1'b0, lat);

    // randomized programs
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 8; i++) begin
        int sel = $urandom_range(0, 9);
        c.op = (sel < 4) ? OPW : (sel < 7) ? OPR : (sel < 9) ? OPI : OPE;
        c.slave = 2'($urandom);
        c.addr = AW'($urandom);
        c.len = (c.op == OPI) ? LW'($urandom_range(0, 5)) : LW'($urandom_range(0, 4));
        c.seed = DW'($urandom);
        c.incr = DW'($urandom);
        write_cmd(i, c);
      end
      run_prog(1'b0, lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not complete, got running, expected finished");
    $fatal(1);
  end

endmodule

// File: doc/master_seq_core.md
Name: master_seq_core

Overview:
- Parametrised, command-driven successor to the fixed-sequence bus master core.
- It runs a program of WRITE, READ, IDLE and END commands held in a writable command table, rather than a sequence hard-wired at elaboration.
- It drives the same master-interface handshake (address request / ok response / data request / done / force), with configurable address and data widths and a response timeout.
- It sits between test or host control logic and the bus master interface.

Parameters:
- ADDR_W, 12: slave-local address width. addr_to_mi is ADDR_W+4 bits wide: {start bit 1, slave[1:0], rw, addr}.
- DATA_W, 8: data width.
- DEPTH_LOG2, 3: command table holds 2**DEPTH_LOG2 entries.
- LEN_W, 8: width of the length/count field.
- TIMEOUT, 255: maximum cycles spent in any wait state. 0 disables the timeout.
- CMD_W, 2+2+ADDR_W+LEN_W+2*DATA_W: command width. Field order, MSB first: op, slave, addr, len, seed, incr.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- cmd_wr_en  in  1  command table write strobe
- cmd_wr_addr  in  DEPTH_LOG2  table index to write
- cmd_wr_data  in  CMD_W  command word
- start  in  1  begin execution at entry 0
- busy  out  1  program running
- done  out  1  one-cycle pulse at program end
- error  out  1  sticky timeout flag
- rd_valid  out  1  one-cycle read-beat strobe
- rd_data  out  DATA_W  captured read data
- rd_addr  out  ADDR_W  address of the captured beat
- addr_to_mi  out  ADDR_W+4  address word to the master interface
- write_addr_req_to_mi  out  1  address request
- write_data_to_mi  out  DATA_W  write data
- write_data_req_to_mi  out  1  write data request
- read_data_req_to_mi  out  1  read data request
- force_req_to_mi  out  1  keep the bus for the next beat of the same command
- ok_response_from_mi  in  1  address accepted
- read_data_from_mi  in  DATA_W  read data
- req_done_from_mi  in  1  data phase complete

Behaviour:
- Reset:
  - Every output goes to 0; state returns to S_IDLE; pc goes to 0; error is cleared.
  - Command table contents are not reset.
- Opcodes: 00 IDLE, 01 WRITE, 10 READ, 11 END.
- Table writes: accepted only when busy=0; ignored while busy. start while busy is ignored.
- States: S_IDLE, FETCH, GAP, SETUP, ADDR_RQ, ADDR_WAIT, WD_SETUP, WD_RQ, RD_RQ, DATA_WAIT, NEXT, FINISH.
- S_IDLE: on start, set busy=1, pc=0, error=0, go to FETCH.
- FETCH:
  - Latch table[pc] into the working registers: beat counter = len, cur_addr = addr, cur_data = seed.
  - WRITE or READ with len>0 goes to SETUP.
  - WRITE or READ with len==0 goes to NEXT (command skipped).
  - IDLE goes to GAP. END goes to FINISH.
- GAP:
  - Decrement the counter each cycle while it is nonzero, then go to NEXT.
  - IDLE with len=N spends exactly N cycles in GAP; N=0 spends none.
- SETUP:
  - addr_to_mi <= {1'b1, slave, rw, cur_addr}, where rw=1 for WRITE and 0 for READ.
  - force_req_to_mi <= 0. Decrement the beat counter.
- ADDR_RQ: write_addr_req_to_mi <= 1.
- ADDR_WAIT:
  - On ok_response_from_mi: drop write_addr_req_to_mi.
  - Next state is WD_SETUP for WRITE, RD_RQ for READ.
- WD_SETUP: write_data_to_mi <= cur_data; cur_data <= cur_data + incr (mod 2**DATA_W).
- WD_RQ: write_data_req_to_mi <= 1.
- RD_RQ: read_data_req_to_mi <= 1.
- DATA_WAIT, on req_done_from_mi:
  - Drop the active data request.
  - For READ, on the same edge: rd_data <= read_data_from_mi, rd_addr <= cur_addr, rd_valid pulses one cycle.
  - cur_addr <= cur_addr + 1, wrapping mod 2**ADDR_W.
  - Beats remaining: force_req_to_mi <= 1, go to SETUP. Otherwise go to NEXT.
- NEXT: if pc is the last entry, go to FINISH; else pc+1 and go to FETCH.
- FINISH:
  - done pulses for one cycle; busy <= 0; all request outputs are 0.
  - Go to S_IDLE. addr_to_mi and write_data_to_mi hold their last values.
- Timing: with start sampled at edge E0, busy is high after E0, addr_to_mi is valid after E2, and write_addr_req_to_mi is high after E3.
- Timeout:
  - The counter clears on entering ADDR_WAIT or DATA_WAIT.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT while waiting: clear all requests and force_req_to_mi, set error=1, go to FINISH.
- Simultaneous ok_response and timeout expiry: the response wins.
- Reset mid-operation: all requests deassert immediately (asynchronous); the program is not resumed.

Test Plan:
- Write table[0]={WRITE, slave 01, addr 400, len 2, seed 170, incr 15} and table[1]=END; pulse start. Required: two beats with addr_to_mi 0xB190 then 0xB191 and data 170 then 185; force_req_to_mi high only between the beats; done pulses once; busy falls.
- Program {READ, slave 01, addr 400, len 2}; bench returns 0x5A then 0xA5. Required: rd_valid pulses twice with (rd_addr, rd_data) = (400, 0x5A) then (401, 0xA5); addr_to_mi = 0xA190.
- Program {WRITE, addr 4095, len 3, seed 250, incr 5}. Required: addresses 4095, 0, 1; data 250, 255, 4 (wraps).
- Program {IDLE, len 110} followed by a WRITE of len 1. Required: exactly 110 GAP cycles between leaving FETCH and the next addr_to_mi update; an IDLE with len 0 adds no GAP cycles.
- TIMEOUT=20 and ok_response_from_mi never asserted. Required: write_addr_req_to_mi drops after 20 wait cycles; error=1; done pulses; a subsequent start clears error.
- Assert reset mid-beat, and attempt cmd_wr_en and start while busy. Required: all outputs are 0 during reset; table contents are retained; writes and start while busy have no effect.
